lfsr_prng_core: RTL and testbench
=================================

// Module: lfsr_prng_core
// PURPOSE
//  Parametrised dual-LFSR pseudo-random byte source. A data LFSR (DATA_W) and a
//  selector LFSR (OUT_W) advance on clock-enable ticks from internal dividers.
//  Each output bit i picks data[2i+1] when sel[i]=1, else data[2i]. Samples go
//  to a valid/ready port that feeds the 7-seg/GPIO top level. Single clock
//  domain; no derived clocks.
// PARAMETERS
//  DATA_W     16         data LFSR width; must equal 2*OUT_W
//  OUT_W      8          output width, also the selector LFSR width
//  DATA_TAPS  16'hD008   feedback mask for the data LFSR (bits 15,14,12,3)
//  SEL_TAPS   8'hB8      feedback mask for the selector LFSR (bits 7,5,4,3)
//  DIV_W      24         width of the divider period inputs
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  en         in   1       run enable, sampled synchronously
//  seed_load  in   1       1-cycle pulse: load seeds
//  seed_data  in   DATA_W  data LFSR seed
//  seed_sel   in   OUT_W   selector LFSR seed
//  div_data   in   DIV_W   data tick period in clk cycles (0 and 1 = every cycle)
//  div_sel    in   DIV_W   selector tick period in clk cycles
//  out_data   out  OUT_W   scrambled sample
//  out_valid  out  1       sample pending
//  out_ready  in   1       consumer accepts the sample
//  overrun    out  1       sticky: a sample was dropped; cleared by seed_load
//  lockup     out  1       1-cycle pulse: all-ones lock-up state was escaped
// BEHAVIOUR
//  Reset: both LFSRs, both dividers, out_data, out_valid, overrun and lockup
//   are all 0.
//  Step (XNOR Fibonacci): next = {s[W-2:0], ~^(s & TAPS)}; 0 is a legal state.
//  Lock-up: a step from all-ones loads 0 instead. lockup pulses for 1 cycle
//   (either LFSR).
//  Divider: counter runs 0..P-1, tick when cnt==P-1, then wraps to 0.
//   P<=1 gives a tick every cycle. If a new P is <= cnt, tick next cycle and wrap.
//  en=0: no ticks, counters cleared to 0, LFSR states held. The output
//   handshake keeps running.
//  seed_load: highest priority over tick and en.
//   - Loads both seeds and clears both counters.
//   - Clears out_valid and overrun. No step happens that cycle.
//  Sample: the cycle after a data step, out_data = mux(new data, current sel).
//   out_valid=1 in that same cycle (latency 1 from tick).
//   A selector step in the same cycle as a data step is visible to that sample.
//  Handshake: out_data is stable while out_valid && !out_ready.
//   Transfer happens when out_valid && out_ready.
//   New sample with no transfer pending: out_valid=1.
//   New sample while the old one is still pending and not taken: new sample
//   dropped, old one held, overrun set.
//   New sample in the same cycle as a transfer: new sample replaces old,
//   out_valid stays 1.
//  Reset mid-operation: asynchronous clear to the reset values above.
//   Resumes from state 0 on the first tick after rst_n rises.
// STRUCTURE
//  prng_pkg: DEFAULT_DATA_TAPS and DEFAULT_SEL_TAPS constants, plus the
//   lfsr_next() function.
//  Sub-module prng_lfsr #(W, TAPS, DIV_W) holds the divider, the LFSR register,
//   seed load and lock-up escape. It is instantiated twice.
//  The top level holds the bit-select mux and the output handshake register.
// TESTING
//  1 Reset, en=1, div_*=1, ready=1. Tick 1 gives data=0x0001, sel=0x01,
//    out=0x00. Tick 2 gives 0x0003, 0x03, out=0x01.
//  2 Data period: 65535 steps from 0 return to 0x0000. 0xFFFF never appears.
//  3 seed_data=0xFFFF, one step -> data=0x0000, lockup pulses exactly 1 cycle.
//  4 div_data=4, div_sel=1 -> out_valid rises every 4th cycle.
//    ready=0 for 10 cycles -> overrun=1 and out_data unchanged.
//  5 seed_load in the same cycle as a tick -> seed loaded, no step, out_valid=0,
//    overrun=0.
//  6 en=0 for 5 cycles mid-count -> states held. After en=1 with div=4, the
//    first tick comes on the 4th cycle.

Source files
------------

// File: rtl/prng_pkg.sv
// Purpose: shared tap constants and the XNOR Fibonacci LFSR step for the PRNG core.
// Latency: pure functions and constants, no state.
// Backpressure: not applicable.
package prng_pkg;

  localparam logic [15:0] DEFAULT_DATA_TAPS = 16'hD008;
  localparam logic [7:0]  DEFAULT_SEL_TAPS  = 8'hB8;
  localparam int          LFSR_MAX_W        = 32;

  // One XNOR Fibonacci step on a register of up to LFSR_MAX_W bits. mask has
  // ones in the live bit positions. All-ones is the XNOR lock-up state, so it
  // is escaped to zero, which is a legal member of the sequence.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] taps,
    input logic [LFSR_MAX_W-1:0] mask
  );
    logic fb;
    fb = ~^(s & taps & mask);
    if ((s & mask) == mask) begin
      return '0;
    end
    return ((s << 1) | {{(LFSR_MAX_W-1){1'b0}}, fb}) & mask;
  endfunction

endpackage

// File: rtl/prng_lfsr.sv
// Purpose: one clock-enabled XNOR LFSR with its own period divider, seed load and lock-up escape.
// Latency: state_next is the value the register takes at the coming edge; tick is combinational.
// Backpressure: none; the generator free-runs whenever en is high.
module prng_lfsr
  import prng_pkg::*;
#(
  parameter int             W     = 16,
  parameter logic [W-1:0]   TAPS  = '0,
  parameter int             DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [W-1:0]     seed,
  input  logic [DIV_W-1:0] period,
  output logic             tick,
  output logic [W-1:0]     state_next,
  output logic             lockup
);

  localparam logic [LFSR_MAX_W-1:0] MASK =
    (W >= LFSR_MAX_W) ? '1 : ((LFSR_MAX_W'(1) << W) - LFSR_MAX_W'(1));

  logic [W-1:0]            state;
  logic [DIV_W-1:0]        cnt;
  logic [LFSR_MAX_W-1:0]   step_w;
  logic                    at_end;

  assign step_w = lfsr_next(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS), MASK);

  if (W < LFSR_MAX_W) begin : g_hi
    logic unused_step_hi;
    assign unused_step_hi = ^step_w[LFSR_MAX_W-1:W];
  end

  // A shrunk period that the counter has already passed ends the count at once.
  assign at_end     = (period <= DIV_W'(1)) || (cnt >= period - DIV_W'(1));
  assign tick       = en && !seed_load && at_end;
  assign state_next = seed_load ? seed : (tick ? step_w[W-1:0] : state);

  // State, divider count and the one-cycle lock-up flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= '0;
      cnt    <= '0;
      lockup <= 1'b0;
    end else begin
      state  <= state_next;
      lockup <= tick && (&state);
      if (seed_load || !en || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/lfsr_prng_core.sv
// Purpose: dual-LFSR pseudo-random sample source; selector LFSR picks one of each data bit pair.
// Latency: sample appears with out_valid one cycle after a data tick.
// Backpressure: an untaken sample is held stable; a new sample arriving then is dropped and flags overrun.
module lfsr_prng_core
  import prng_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                OUT_W     = 8,
  parameter logic [DATA_W-1:0] DATA_TAPS = DEFAULT_DATA_TAPS,
  parameter logic [OUT_W-1:0]  SEL_TAPS  = DEFAULT_SEL_TAPS,
  parameter int                DIV_W     = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              seed_load,
  input  logic [DATA_W-1:0] seed_data,
  input  logic [OUT_W-1:0]  seed_sel,
  input  logic [DIV_W-1:0]  div_data,
  input  logic [DIV_W-1:0]  div_sel,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              lockup
);

  logic              data_tick;
  logic              sel_tick_unused;
  logic [DATA_W-1:0] data_next;
  logic [OUT_W-1:0]  sel_next;
  logic              data_lock;
  logic              sel_lock;
  logic [OUT_W-1:0]  sample;

  prng_lfsr #(.W(DATA_W), .TAPS(DATA_TAPS), .DIV_W(DIV_W)) u_data (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .seed_load  (seed_load),
    .seed       (seed_data),
    .period     (div_data),
    .tick       (data_tick),
    .state_next (data_next),
    .lockup     (data_lock)
  );

  prng_lfsr #(.W(OUT_W), .TAPS(SEL_TAPS), .DIV_W(DIV_W)) u_sel (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .seed_load  (seed_load),
    .seed       (seed_sel),
    .period     (div_sel),
    .tick       (sel_tick_unused),
    .state_next (sel_next),
    .lockup     (sel_lock)
  );

  assign lockup = data_lock | sel_lock;

  // Bit-pair select on the post-step values, so a coincident selector step is seen.
  always_comb begin
    sample = '0;
    for (int i = 0; i < OUT_W; i++) begin
      sample[i] = sel_next[i] ? data_next[2*i+1] : data_next[2*i];
    end
  end

  // Output holding register: a sample in flight is never overwritten until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (seed_load) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (data_tick) begin
      if (!out_valid || out_ready) begin
        out_data  <= sample;
        out_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_prng_core.sv
// Purpose: self-checking bench for lfsr_prng_core against a behavioural model.
// Latency: model outputs compared 1 ns after every rising edge.
// Backpressure: out_ready driven from tables, fixed sequences and random draws.
module tb_lfsr_prng_core;

  logic        clk = 1'b0;
  logic        rst_n, en, seed_load, out_valid, out_ready, overrun, lockup;
  logic [15:0] seed_data;
  logic [7:0]  seed_sel, out_data;
  logic [23:0] div_data, div_sel;

  int n_chk  = 0;
  int n_pass = 0;

  lfsr_prng_core u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .seed_load (seed_load),
    .seed_data (seed_data),
    .seed_sel  (seed_sel),
    .div_data  (div_data),
    .div_sel   (div_sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .lockup    (lockup)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural reference ----------------
  int unsigned m_data, m_sel, m_cnt_d, m_cnt_s, m_out;
  bit          m_valid, m_ovr, m_lock;

  function automatic int unsigned ref_step(input int unsigned s, input int unsigned taps, input int w);
    int unsigned full;
    int ones;
    full = (32'd1 << w) - 1;
    ones = 0;
    if (s == full) return 0;
    for (int b = 0; b < w; b++) if (((s & taps) >> b) & 1) ones++;
    return ((s * 2) + ((ones % 2 == 0) ? 1 : 0)) & full;
  endfunction

  function automatic int unsigned ref_mux(input int unsigned d, input int unsigned s);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 8; i++) r |= ((d >> (2 * i + ((s >> i) & 1))) & 1) << i;
    return r;
  endfunction

  function automatic bit ref_tick(input int unsigned cnt, input int unsigned p);
    return (p <= 1) || (cnt + 1 >= p);
  endfunction

  task automatic model_reset();
    m_data = 0; m_sel = 0; m_cnt_d = 0; m_cnt_s = 0; m_out = 0;
    m_valid = 0; m_ovr = 0; m_lock = 0;
  endtask

  task automatic model_edge();
    bit td, ts, xfer;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (seed_load) begin
      m_data = seed_data; m_sel = seed_sel; m_cnt_d = 0; m_cnt_s = 0;
      m_valid = 0; m_ovr = 0; m_lock = 0;
      return;
    end
    td = en && ref_tick(m_cnt_d, div_data);
    ts = en && ref_tick(m_cnt_s, div_sel);
    m_cnt_d = (!en || td) ? 0 : m_cnt_d + 1;
    m_cnt_s = (!en || ts) ? 0 : m_cnt_s + 1;
    m_lock  = (td && m_data == 32'hFFFF) || (ts && m_sel == 32'hFF);
    if (td) m_data = ref_step(m_data, 32'hD008, 16);
    if (ts) m_sel  = ref_step(m_sel, 32'hB8, 8);
    xfer = m_valid && out_ready;
    if (td) begin
      if (!m_valid || xfer) begin
        m_out   = ref_mux(m_data, m_sel);
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (xfer) begin
      m_valid = 0;
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("model {out_data,valid,overrun,lockup}",
          {53'd0, out_data, out_valid, overrun, lockup},
          {53'd0, m_out[7:0], m_valid, m_ovr, m_lock});
  endtask

  task automatic drive(input bit e, input bit ld, input logic [15:0] sd, input logic [7:0] ss,
                       input logic [23:0] dd, input logic [23:0] ds, input bit rdy);
    en = e; seed_load = ld; seed_data = sd; seed_sel = ss;
    div_data = dd; div_sel = ds; out_ready = rdy;
  endtask

  typedef struct {
    bit          en;
    bit          ld;
    logic [15:0] sd;
    logic [7:0]  ss;
    logic [23:0] dd;
    logic [23:0] ds;
    bit          rdy;
    logic [7:0]  eo;
    bit          ev;
    bit          eov;
    bit          el;
  } vec_t;

  vec_t vt[12];

  initial begin
    int ones_seen, early_zero;
    logic [7:0] hold;

    vt[0]  = '{1'b1, 1'b0, 16'h0000, 8'h00, 24'd1, 24'd1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 16'h0000, 8'h00, 24'd1, 24'd1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 16'h0000, 8'h00, 24'd1, 24'd1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 16'h0000, 8'h00, 24'd1, 24'd1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 16'hFFFF, 8'h00, 24'd1, 24'd1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 16'h0000, 8'h00, 24'd1, 24'd1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 16'h0000, 8'h00, 24'd1, 24'd1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 16'h0000, 8'h00, 24'd1, 24'd1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 16'h0000, 8'h00, 24'd1, 24'd1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 24'd1, 24'd1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b0, 16'h0000, 8'h00, 24'd1, 24'd1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0};
    vt[11] = '{1'b1, 1'b1, 16'h0000, 8'h00, 24'd1, 24'd1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 8'h0, 24'd1, 24'd1, 1'b1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset out_data", {56'd0, out_data}, 64'h0);
    check("reset out_valid", {63'd0, out_valid}, 64'h0);
    check("reset overrun", {63'd0, overrun}, 64'h0);
    check("reset lockup", {63'd0, lockup}, 64'h0);
    rst_n = 1'b1;

    // Table: first steps, lock-up escape, overrun, seed load racing a tick.
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].en, vt[i].ld, vt[i].sd, vt[i].ss, vt[i].dd, vt[i].ds, vt[i].rdy);
      cyc();
      check($sformatf("vec%0d out_data", i), {56'd0, out_data}, {56'd0, vt[i].eo});
      check($sformatf("vec%0d out_valid", i), {63'd0, out_valid}, {63'd0, vt[i].ev});
      check($sformatf("vec%0d overrun", i), {63'd0, overrun}, {63'd0, vt[i].eov});
      check($sformatf("vec%0d lockup", i), {63'd0, lockup}, {63'd0, vt[i].el});
    end

    // Divider period 4: a sample every 4th cycle, then a stalled consumer.
    drive(1'b1, 1'b0, 16'h0, 8'h0, 24'd4, 24'd1, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check($sformatf("div4 valid c%0d", k), {63'd0, out_valid}, {63'd0, (k % 4 == 0)});
    end
    hold = m_out[7:0];
    out_ready = 1'b0;
    repeat (10) cyc();
    check("stall overrun", {63'd0, overrun}, 64'h1);
    check("stall out_data held", {56'd0, out_data}, {56'd0, hold});
    check("stall out_valid", {63'd0, out_valid}, 64'h1);

    // en low mid-count holds state and restarts the divider from zero.
    drive(1'b1, 1'b1, 16'h1234, 8'h5A, 24'd4, 24'd1, 1'b1);
    cyc();
    seed_load = 1'b0;
    repeat (2) cyc();
    en = 1'b0;
    repeat (5) cyc();
    check("en0 data state held", {48'd0, u_dut.u_data.state}, {48'd0, m_data[15:0]});
    check("en0 data state is seed", {48'd0, u_dut.u_data.state}, 64'h1234);
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check($sformatf("resume valid c%0d", k), {63'd0, out_valid}, {63'd0, (k == 4)});
    end

    // Asynchronous reset in the middle of a cycle, then restart from zero.
    drive(1'b1, 1'b0, 16'h0, 8'h0, 24'd1, 24'd1, 1'b1);
    repeat (3) cyc();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async rst out_valid", {63'd0, out_valid}, 64'h0);
    check("async rst out_data", {56'd0, out_data}, 64'h0);
    check("async rst data state", {48'd0, u_dut.u_data.state}, 64'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("post rst out_valid", {63'd0, out_valid}, 64'h1);
    check("post rst out_data", {56'd0, out_data}, 64'h0);
    check("post rst data state", {48'd0, u_dut.u_data.state}, 64'h1);

    // Full data-LFSR period from zero; the lock-up value must never appear.
    drive(1'b1, 1'b1, 16'h0, 8'h0, 24'd1, 24'd1, 1'b1);
    cyc();
    seed_load = 1'b0;
    ones_seen = 0;
    early_zero = 0;
    for (int i = 1; i <= 65535; i++) begin
      cyc();
      if (u_dut.u_data.state == 16'hFFFF) ones_seen++;
      if (i < 65535 && u_dut.u_data.state == 16'h0000) early_zero++;
    end
    check("period end state", {48'd0, u_dut.u_data.state}, 64'h0);
    check("period all-ones seen", 64'(ones_seen), 64'h0);
    check("period early zero", 64'(early_zero), 64'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom % 8) != 0;
      seed_load = ($urandom % 64) == 0;
      seed_data = (($urandom % 4) == 0) ? 16'hFFFF : 16'($urandom);
      seed_sel  = (($urandom % 4) == 0) ? 8'hFF : 8'($urandom);
      if (($urandom % 16) == 0) div_data = 24'($urandom_range(0, 5));
      if (($urandom % 16) == 0) div_sel  = 24'($urandom_range(0, 5));
      out_ready = ($urandom % 3) != 0;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
